// File: rtl/jrc_param.sv
// Parametrised Johnson ring counter: bidirectional step, validated load, phase index, wrap pulse/count, sticky load error.
// Latency: 1 cycle from CE/LD to Q, PHASE, TC, WRAPS and ERR; every output comes straight from a register.
// Backpressure: none; CE is the only throttle and every enabled edge steps the sequence.
module jrc_param #(
    parameter int WIDTH = 10,
    parameter int CYC_W = 16,
    parameter int PW    = $clog2(2*WIDTH)
) (
    input  logic             C,
    input  logic             R,
    input  logic             CE,
    input  logic             DIR,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [PW-1:0]    PHASE,
    output logic             TC,
    output logic [CYC_W-1:0] WRAPS,
    output logic             ERR
);
    localparam logic [PW-1:0] PH_LAST = PW'(2*WIDTH-1);
    localparam logic [PW:0]   PH_SPAN = (PW+1)'(2*WIDTH);

    logic [WIDTH-1:0] q_q, q_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic             tc_q, tc_d;
    logic [CYC_W-1:0] wraps_q, wraps_d;
    logic             err_q, err_d;

    logic [PW:0]      ld_ones;
    logic [PW:0]      ld_edges;
    logic             ld_legal;
    logic [PW-1:0]    ld_phase;
    logic             wrap;

    // A Johnson pattern has at most one boundary between its run of ones and its run of zeros.
    always_comb begin
        ld_ones  = '0;
        ld_edges = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ld_ones = ld_ones + {{PW{1'b0}}, D[i]};
        end
        for (int i = 0; i < WIDTH-1; i++) begin
            ld_edges = ld_edges + {{PW{1'b0}}, D[i] ^ D[i+1]};
        end
        ld_legal = (ld_edges <= (PW+1)'(1));
        ld_phase = D[WIDTH-1] ? PW'(PH_SPAN - ld_ones) : PW'(ld_ones);
    end

    always_comb begin
        q_d     = q_q;
        phase_d = phase_q;
        tc_d    = 1'b0;
        wraps_d = wraps_q;
        err_d   = err_q;
        wrap    = 1'b0;
        if (LD) begin
            if (ld_legal) begin
                q_d     = D;
                phase_d = ld_phase;
            end else begin
                q_d     = '0;
                phase_d = '0;
                err_d   = 1'b1;
            end
        end else if (CE) begin
            if (!DIR) begin
                q_d     = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
                wrap    = (phase_q == PH_LAST);
                phase_d = wrap ? '0 : phase_q + PW'(1);
            end else begin
                q_d     = {~q_q[0], q_q[WIDTH-1:1]};
                wrap    = (phase_q == '0);
                phase_d = wrap ? PH_LAST : phase_q - PW'(1);
            end
            tc_d = wrap;
            if (wrap && (wraps_q != '1)) begin
                wraps_d = wraps_q + CYC_W'(1);
            end
        end
    end

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            q_q     <= '0;
            phase_q <= '0;
            tc_q    <= 1'b0;
            wraps_q <= '0;
            err_q   <= 1'b0;
        end else begin
            q_q     <= q_d;
            phase_q <= phase_d;
            tc_q    <= tc_d;
            wraps_q <= wraps_d;
            err_q   <= err_d;
        end
    end

    assign Q     = q_q;
    assign PHASE = phase_q;
    assign TC    = tc_q;
    assign WRAPS = wraps_q;
    assign ERR   = err_q;
endmodule
